// File: rtl/conv1_out_pkg.sv
// Shared types and constants for the conv1 output collector.
package conv1_out_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Largest positive two's-complement value of width w, zero-extended to 64 bits.
  function automatic logic [63:0] sat_hi_bits(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  localparam logic [DATA_W_DEF-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W_DEF-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/conv1_sat_relu.sv
// Registered stage 1: bias add at DATA_W+1 bits, clamp, optional ReLU.
// Build option: CONV1_OUT_RELU_EN forces negative saturated results to zero.
module conv1_sat_relu
  import conv1_out_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_v,
  input  logic              i_last,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_bias,
  output logic              o_v,
  output logic              o_last,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [63:0]       HI_L = sat_hi_bits(DATA_W);
  localparam logic [DATA_W-1:0] W_HI = (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MAX) : HI_L[DATA_W-1:0];
  localparam logic [DATA_W-1:0] W_LO = (DATA_W == DATA_W_DEF) ? DATA_W'(SAT_MIN) : ~HI_L[DATA_W-1:0];

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_sat;
  logic [DATA_W-1:0] w_res;

  // Sign-extended add; the two top bits disagree exactly on overflow.
  always_comb begin
    w_sum = {i_data[DATA_W-1], i_data} + {i_bias[DATA_W-1], i_bias};
    w_sat = w_sum[DATA_W-1:0];
    w_res = w_sat;
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      if (w_sum[DATA_W]) begin
        w_sat = W_LO;
      end else begin
        w_sat = W_HI;
      end
    end else begin
      w_sat = w_sum[DATA_W-1:0];
    end
`ifdef CONV1_OUT_RELU_EN
    if (w_sat[DATA_W-1]) begin
      w_res = '0;
    end else begin
      w_res = w_sat;
    end
`else
    w_res = w_sat;
`endif
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_v    <= 1'b0;
      o_last <= 1'b0;
      o_data <= '0;
    end else begin
      o_v    <= i_v;
      o_last <= i_last;
      o_data <= w_res;
    end
  end

endmodule

// File: rtl/conv1_out_collector.sv
// conv1 output collector: bias/saturate stage, lane packer and frame FSM.
// Build option: define CONV1_OUT_RELU_EN to clamp negative results to zero.
module conv1_out_collector
  import conv1_out_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PACK    = 4,
  parameter int OUT_NUM = 576,
  parameter int ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   data_v,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [DATA_W-1:0]      bias,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [DATA_W*PACK-1:0] wr_data,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int CNT_W  = $clog2(OUT_NUM + 1);
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int WORD_W = DATA_W * PACK;

  state_e            r_state;
  state_e            w_next_state;
  logic [CNT_W-1:0]  r_elem_cnt;
  logic [LANE_W-1:0] r_lane_idx;
  logic [WORD_W-1:0] r_acc;
  logic [WORD_W-1:0] w_acc_next;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic              r_wr_en;
  logic              r_wr_last;
  logic              r_busy;
  logic              r_frame_done;
  logic              w_arm;
  logic              w_accept;
  logic              w_last;
  logic              w_s1_v;
  logic              w_s1_last;
  logic [DATA_W-1:0] w_s1_data;
  logic              w_word_done;

  assign w_arm       = (r_state == IDLE) && start;
  assign w_accept    = (r_state == RUN) && data_v;
  assign w_last      = w_accept && (r_elem_cnt == CNT_W'(OUT_NUM - 1));
  assign w_word_done = w_s1_v && ((r_lane_idx == LANE_W'(PACK - 1)) || w_s1_last);

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  conv1_sat_relu #(
    .DATA_W (DATA_W)
  ) u_sat_relu (
    .clk    (clk),
    .rst    (rst),
    .i_v    (w_accept),
    .i_last (w_last),
    .i_data (in_data),
    .i_bias (bias),
    .o_v    (w_s1_v),
    .o_last (w_s1_last),
    .o_data (w_s1_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // DRAIN leaves only once the word carrying the last sample is on the port.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = RUN;
        else       w_next_state = IDLE;
      end
      RUN: begin
        if (w_last) w_next_state = DRAIN;
        else        w_next_state = RUN;
      end
      DRAIN: begin
        if (r_wr_en && r_wr_last) w_next_state = DONE;
        else                      w_next_state = DRAIN;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_busy       <= (w_next_state == RUN) || (w_next_state == DRAIN);
      r_frame_done <= (w_next_state == DONE);
    end
  end

  // Accepted-sample counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_elem_cnt <= '0;
    end else if (w_arm) begin
      r_elem_cnt <= '0;
    end else if (w_accept) begin
      r_elem_cnt <= r_elem_cnt + CNT_W'(1);
    end else begin
      r_elem_cnt <= r_elem_cnt;
    end
  end

  // Current accumulator with the incoming result dropped into its lane.
  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < PACK; k++) begin
      if (LANE_W'(k) == r_lane_idx) begin
        w_acc_next[k*DATA_W +: DATA_W] = w_s1_data;
      end else begin
        w_acc_next[k*DATA_W +: DATA_W] = r_acc[k*DATA_W +: DATA_W];
      end
    end
  end

  // Packer; the accumulator is cleared on every write so unfilled lanes read 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lane_idx <= '0;
      r_acc      <= '0;
      r_addr_cnt <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_last  <= 1'b0;
    end else if (w_arm) begin
      r_lane_idx <= '0;
      r_acc      <= '0;
      r_addr_cnt <= '0;
      r_wr_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_last  <= 1'b0;
    end else begin
      r_wr_addr <= r_addr_cnt;
      r_wr_en   <= w_word_done;
      r_wr_last <= w_word_done && w_s1_last;
      if (w_word_done) begin
        r_wr_data  <= w_acc_next;
        r_acc      <= '0;
        r_lane_idx <= '0;
        r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
      end else if (w_s1_v) begin
        r_acc      <= w_acc_next;
        r_lane_idx <= r_lane_idx + LANE_W'(1);
      end else begin
        r_acc      <= r_acc;
        r_lane_idx <= r_lane_idx;
      end
    end
  end

endmodule

// File: tb/tb_conv1_out_collector.sv
// Bench for conv1_out_collector: two instances (OUT_NUM 8 and 6) against a scoreboard model.
module tb_conv1_out_collector;

  localparam int MAXC = 8192;
`ifdef CONV1_OUT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  typedef struct {
    logic [15:0] b;
    logic [15:0] x;
    logic [15:0] exp;
  } sat_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, data_v;
  logic [15:0] in_data, bias;
  logic        wr_en_a, wr_en_b, busy_a, busy_b, fd_a, fd_b;
  logic [7:0]  wr_addr_a, wr_addr_b;
  logic [63:0] wr_data_a, wr_data_b;

  conv1_out_collector #(.DATA_W(16), .PACK(4), .OUT_NUM(8), .ADDR_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .data_v(data_v), .in_data(in_data), .bias(bias),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a), .frame_done(fd_a));

  conv1_out_collector #(.DATA_W(16), .PACK(4), .OUT_NUM(6), .ADDR_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .data_v(data_v), .in_data(in_data), .bias(bias),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b), .frame_done(fd_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          e_wr[2][MAXC];
  logic [63:0] e_data[2][MAXC];
  logic [7:0]  e_addr[2][MAXC];
  bit          e_fd[2][MAXC];
  bit          e_busy[2][MAXC];

  int          m_phase[2];
  int          m_cnt[2];
  int          m_addr[2];
  int          m_done[2];
  int          m_nl[2];
  logic [15:0] m_lane[2][4];

  logic [63:0] ob_data[2][64];
  logic [7:0]  ob_addr[2][64];
  int          ob_cnt[2];
  int          fd_cyc[2];

  function automatic int out_num(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic logic [15:0] ref_calc(input logic [15:0] x, input logic [15:0] b);
    int s;
    s = int'($signed(x)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    if (RELU && s < 0) s = 0;
    return s[15:0];
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s out_num=%0d cyc=%0d: got %h expected %h", nm, out_num(d), cyc, act, exp);
    end
  endtask

  // Spec-level model: c is the cycle in which the inputs are driven.
  task automatic model_step(input int d, input int c, input bit rn, input bit st, input bit dv,
                            input logic [15:0] x, input logic [15:0] b);
    logic [63:0] word;
    if (!rn) begin
      for (int k = c + 1; k <= c + 4; k++) begin
        e_wr[d][k] = 1'b0;
        e_fd[d][k] = 1'b0;
      end
      m_phase[d] = 0; m_cnt[d] = 0; m_nl[d] = 0; m_addr[d] = 0;
      e_busy[d][c+1] = 1'b0;
      return;
    end
    if (m_phase[d] == 2 && c > m_done[d]) m_phase[d] = 0;
    if (m_phase[d] == 0) begin
      if (st) begin
        m_phase[d] = 1; m_cnt[d] = 0; m_nl[d] = 0; m_addr[d] = 0;
      end
    end else if (m_phase[d] == 1 && dv) begin
      m_lane[d][m_nl[d]] = ref_calc(x, b);
      m_nl[d]++;
      m_cnt[d]++;
      if (m_nl[d] == 4 || m_cnt[d] == out_num(d)) begin
        word = '0;
        for (int k = 0; k < m_nl[d]; k++) word[k*16 +: 16] = m_lane[d][k];
        e_wr[d][c+2]   = 1'b1;
        e_data[d][c+2] = word;
        e_addr[d][c+2] = 8'(m_addr[d]);
        m_addr[d]      = (m_addr[d] + 1) % 256;
        m_nl[d]        = 0;
      end
      if (m_cnt[d] == out_num(d)) begin
        m_phase[d]   = 2;
        m_done[d]    = c + 3;
        e_fd[d][c+3] = 1'b1;
      end
    end
    e_busy[d][c+1] = (m_phase[d] == 1) || (m_phase[d] == 2 && (c + 1) < m_done[d]);
  endtask

  task automatic check_outputs();
    logic we, fdv, bz;
    logic [7:0]  ad;
    logic [63:0] wd;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        we = wr_en_a; fdv = fd_a; bz = busy_a; ad = wr_addr_a; wd = wr_data_a;
      end else begin
        we = wr_en_b; fdv = fd_b; bz = busy_b; ad = wr_addr_b; wd = wr_data_b;
      end
      chk("wr_en", d, 64'(we), 64'(e_wr[d][cyc]));
      if (e_wr[d][cyc]) begin
        chk("wr_addr", d, 64'(ad), 64'(e_addr[d][cyc]));
        chk("wr_data", d, wd, e_data[d][cyc]);
      end
      chk("frame_done", d, 64'(fdv), 64'(e_fd[d][cyc]));
      chk("busy", d, 64'(bz), 64'(e_busy[d][cyc]));
      if (we === 1'b1) begin
        if (ob_cnt[d] < 64) begin
          ob_data[d][ob_cnt[d]] = wd;
          ob_addr[d][ob_cnt[d]] = ad;
        end
        ob_cnt[d]++;
      end
      if (fdv === 1'b1) fd_cyc[d] = cyc;
    end
  endtask

  task automatic step(input bit rn, input bit st, input bit dv, input logic [15:0] x, input logic [15:0] b);
    if (cyc + 5 >= MAXC) begin
      $display("FAIL cycle_budget: got cyc %0d expected below %0d", cyc, MAXC - 5);
      $fatal(1, "cycle budget exhausted");
    end
    rst = rn; start = st; data_v = dv; in_data = x; bias = b;
    for (int d = 0; d < 2; d++) model_step(d, cyc, rn, st, dv, x, b);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n, input logic [15:0] b);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, b);
  endtask

  task automatic clr_obs();
    for (int d = 0; d < 2; d++) begin
      ob_cnt[d] = 0;
      fd_cyc[d] = -1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  sat_vec_t    tv[10];
  int          s_cyc[16];
  int          sel, rst_at;
  bit          do_rst, r_dv, r_st;
  logic [15:0] cur_b, r_x;

  initial begin
    tv[0] = '{16'h7F00, 16'h0200, 16'h7FFF};
    tv[1] = '{16'h8000, 16'hFFFF, RELU ? 16'h0000 : 16'h8000};
    tv[2] = '{16'h0000, 16'h0005, 16'h0005};
    tv[3] = '{16'hFFFF, 16'h0000, RELU ? 16'h0000 : 16'hFFFF};
    tv[4] = '{16'h0100, 16'h0023, 16'h0123};
    tv[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    tv[6] = '{16'h8000, 16'h8000, RELU ? 16'h0000 : 16'h8000};
    tv[7] = '{16'h0010, 16'hFFF0, 16'h0000};
    tv[8] = '{16'hFFF6, 16'h0005, RELU ? 16'h0000 : 16'hFFFB};
    tv[9] = '{16'h4000, 16'h4000, 16'h7FFF};

    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_cnt[d] = 0; m_addr[d] = 0; m_done[d] = 0; m_nl[d] = 0;
    end
    clr_obs();

    // Reset, with start asserted: reset wins.
    step(1'b0, 1'b1, 1'b1, 16'h1234, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("reset_wr_addr", 0, 64'(wr_addr_a), 64'd0);
    chk("reset_wr_data", 0, wr_data_a, 64'd0);
    chk("reset_wr_data", 1, wr_data_b, 64'd0);

    // data_v while IDLE is ignored.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 16'(i + 7), 16'h0000);
    idle(3, 16'h0000);
    chk("idle_no_write", 0, 64'(ob_cnt[0]), 64'd0);
    chk("idle_no_write", 1, 64'(ob_cnt[1]), 64'd0);

    // Basic contiguous frame; the OUT_NUM=6 instance sees 7,8 during DRAIN.
    clr_obs(); cur_b = 16'h0000;
    step(1'b1, 1'b1, 1'b0, 16'h0000, cur_b);
    for (int i = 1; i <= 8; i++) begin
      s_cyc[i] = cyc;
      step(1'b1, 1'b0, 1'b1, 16'(i), cur_b);
    end
    idle(5, cur_b);
    chk("basic_nwr", 0, 64'(ob_cnt[0]), 64'd2);
    chk("basic_w0", 0, ob_data[0][0], 64'h0004_0003_0002_0001);
    chk("basic_a0", 0, 64'(ob_addr[0][0]), 64'd0);
    chk("basic_w1", 0, ob_data[0][1], 64'h0008_0007_0006_0005);
    chk("basic_a1", 0, 64'(ob_addr[0][1]), 64'd1);
    chk("basic_done_lat", 0, 64'(fd_cyc[0] - s_cyc[8]), 64'd3);
    chk("addr_hold", 0, 64'(wr_addr_a), 64'd2);
    chk("part_nwr", 1, 64'(ob_cnt[1]), 64'd2);
    chk("part_w1", 1, ob_data[1][1], 64'h0000_0000_0006_0005);
    chk("part_done_lat", 1, 64'(fd_cyc[1] - s_cyc[6]), 64'd3);

    // Gapped valid with a start pulse mid-RUN.
    clr_obs();
    step(1'b1, 1'b1, 1'b0, 16'h0000, cur_b);
    for (int i = 1; i <= 8; i++) begin
      s_cyc[i] = cyc;
      step(1'b1, 1'b0, 1'b1, 16'(i), cur_b);
      step(1'b1, (i == 3), 1'b0, 16'h0000, cur_b);
      step(1'b1, 1'b0, 1'b0, 16'h0000, cur_b);
    end
    idle(3, cur_b);
    chk("gap_w0", 0, ob_data[0][0], 64'h0004_0003_0002_0001);
    chk("gap_w1", 0, ob_data[0][1], 64'h0008_0007_0006_0005);
    chk("gap_done_lat", 0, 64'(fd_cyc[0] - s_cyc[8]), 64'd3);
    chk("gap_part_w1", 1, ob_data[1][1], 64'h0000_0000_0006_0005);

    // Reset after three samples, then a fresh four-sample word at addr 0.
    clr_obs();
    step(1'b1, 1'b1, 1'b0, 16'h0000, cur_b);
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b1, 16'(i), cur_b);
    step(1'b0, 1'b1, 1'b1, 16'h0004, cur_b);
    chk("rst_mid_wr_en", 0, 64'(wr_en_a), 64'd0);
    chk("rst_mid_busy", 0, 64'(busy_a), 64'd0);
    idle(4, cur_b);
    chk("rst_mid_nwr", 0, 64'(ob_cnt[0]), 64'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0000, cur_b);
    for (int i = 10; i <= 13; i++) step(1'b1, 1'b0, 1'b1, 16'(i), cur_b);
    idle(3, cur_b);
    chk("rst_fresh_w0", 0, ob_data[0][0], 64'h000D_000C_000B_000A);
    chk("rst_fresh_a0", 0, 64'(ob_addr[0][0]), 64'd0);
    chk("rst_fresh_a0", 1, 64'(ob_addr[1][0]), 64'd0);
    idle(8, cur_b);

    // Saturation table: eight identical samples per frame, every lane equal.
    for (int v = 0; v < 10; v++) begin
      clr_obs();
      step(1'b1, 1'b1, 1'b0, 16'h0000, tv[v].b);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, tv[v].x, tv[v].b);
      idle(5, tv[v].b);
      chk("sat_tbl", 0, ob_data[0][0], {tv[v].exp, tv[v].exp, tv[v].exp, tv[v].exp});
    end

    // Randomized frames with gaps, stray starts and occasional resets.
    for (int f = 0; f < 30; f++) begin
      sel    = int'($urandom_range(0, 3));
      cur_b  = (sel == 0) ? 16'h7F00 : (sel == 1) ? 16'h8000 : 16'($urandom);
      do_rst = ($urandom_range(0, 5) == 0);
      rst_at = int'($urandom_range(2, 20));
      step(1'b1, 1'b1, 1'b0, 16'h0000, cur_b);
      for (int k = 0; k < 40; k++) begin
        r_dv = ($urandom_range(0, 2) != 0);
        r_st = ($urandom_range(0, 15) == 0);
        r_x  = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 16'h7FF0 : 16'h8010)
                                            : 16'($urandom);
        step(!(do_rst && k == rst_at), r_st, r_dv, r_x, cur_b);
      end
      idle(6, cur_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1_out_collector.md
# conv1_out_collector

Downstream consumer of the conv1 layer1 25-wise adder-tree result stream. Takes each 16-bit dot-product result with its valid strobe, adds a per-channel bias with saturation, optionally applies ReLU, and packs PACK results into one wide word. Each packed word is written to the conv1 output feature BRAM at an incrementing address. Reports frame completion once OUT_NUM results have been collected.

## Interface
Parameters:
- DATA_W, 16, width of one result (signed, two's complement).
- PACK, 4, results per output word.
- OUT_NUM, 576, results per frame (24x24 conv1 output map).
- ADDR_W, 8, output BRAM address width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; arms a new frame.
- data_v  in  1  in_data valid (adder-tree add_res_v).
- in_data  in  DATA_W  adder-tree sum.
- bias  in  DATA_W  signed channel bias, stable for the whole frame.
- wr_en  out  1  output BRAM write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W*PACK  packed word; result k in bits [k*DATA_W +: DATA_W].
- busy  out  1  high from start acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the final write.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 clears elem_cnt, lane_idx and wr_addr, then enters RUN. data_v is ignored.
- RUN: each data_v=1 cycle accepts one sample and increments elem_cnt. The sample with elem_cnt==OUT_NUM-1 is tagged last, and the FSM enters DRAIN. start is ignored.
- DRAIN: waits until the last sample's word is written, then enters DONE. data_v is ignored.
- DONE: frame_done=1 for one cycle, busy=0, then IDLE.
- Stage 1 arithmetic:
  - sum = sext(in_data) + sext(bias), computed at DATA_W+1 bits.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - ReLU per Configuration.
- Stage 2 packing: the result goes into lane lane_idx and lane_idx increments. When lane_idx==PACK-1 or the sample is tagged last:
  - register wr_en=1 with the word;
  - unfilled lanes are 0;
  - lane_idx returns to 0;
  - wr_addr increments after the write.
- wr_addr wraps modulo 2^ADDR_W. OUT_NUM/PACK must be ≤ 2^ADDR_W; this is not checked at runtime.
- Reset low at any cycle: next edge forces IDLE; all counters, lanes and outputs go to 0. The partial frame is discarded with no further writes.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0.
- Accepted sample at cycle t: stage-1 register at t+1; wr_en (if the word completes) at t+2.
- wr_addr is the address of the current write while wr_en=1. It holds its post-increment value afterward.
- frame_done at t+3 relative to the last sample's data_v.
- busy rises the cycle after start and falls in the same cycle frame_done rises.
- Back-to-back data_v every cycle is supported; no backpressure exists.
- start coincident with rst low: reset wins.

## Configuration
- CONV1_OUT_RELU_EN defined: a saturated result < 0 becomes 0.
- Not defined: the saturated signed result is passed through unchanged.
- Latency is identical in both builds.

## Structure
- Package conv1_out_pkg holds:
  - DATA_W default;
  - state enum (IDLE/RUN/DRAIN/DONE);
  - saturation bound constants.
- Sub-module conv1_sat_relu holds the registered stage 1: bias add, clamp and macro-controlled ReLU, with valid/last passthrough.
- FSM, counters and packer stay in the top.

## Test plan
- Basic frame, OUT_NUM=8, PACK=4, bias=0, in_data 1..8 one per cycle: two writes.
  - addr0 = 0x0004_0003_0002_0001 and addr1 = 0x0008_0007_0006_0005.
  - frame_done three cycles after sample 8.
- Saturation: bias=0x7F00, in_data=0x0200 → lane 0x7FFF. bias=0x8000, in_data=0xFFFF → 0x8000 without macro, 0x0000 with macro.
- Partial word, OUT_NUM=6, PACK=4, in_data 1..6: second write = 0x0000_0000_0006_0005; frame_done follows.
- Gapped valid (data_v every third cycle) → same words as contiguous; start pulsed mid-RUN is ignored.
- Reset mid-frame after 3 samples → no wr_en and busy=0 next cycle. A fresh start plus 4 samples writes at addr 0.
- data_v while IDLE/DRAIN → no counter change; wr_en stays 0.
